// File: rtl/mem_copy.sv
// Register-programmed word copy engine: reads one word from SRC, writes it to DST,
// and repeats for LEN words over a simple valid/ready memory bus.
module mem_copy #(
  parameter int LEN_WIDTH = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        we,
  input  logic [7:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [2:0] {IDLE, READ, GAP_R, WRITE, GAP_W} state_t;

  state_t               state_reg, state_next;
  logic [29:0]          src_reg, dst_reg, src_cnt_reg, dst_cnt_reg;
  logic [LEN_WIDTH-1:0] len_reg, remain_reg;
  logic [31:0]          buf_reg;
  logic                 done_reg, aborted_reg, abort_pend_reg;

  logic busy, wr_en, ctrl_wr, start_req, abort_req, abort_hit;

  assign busy      = (state_reg != IDLE);
  assign wr_en     = cs & we;
  assign ctrl_wr   = wr_en & (address == 8'h08);
  assign abort_req = ctrl_wr & write_data[1];
  // Start together with abort is treated as abort only.
  assign start_req = ctrl_wr & write_data[0] & ~write_data[1];
  assign abort_hit = abort_pend_reg | abort_req;
  assign ready     = cs;

  always_comb begin
    read_data = 32'h0;
    if (cs && !we) begin
      case (address)
        8'h09:   read_data = {29'h0, aborted_reg, done_reg, busy};
        8'h10:   read_data = {src_reg, 2'b00};
        8'h11:   read_data = {dst_reg, 2'b00};
        8'h12:   read_data = {{(32-LEN_WIDTH){1'b0}}, len_reg};
        8'h13:   read_data = {{(32-LEN_WIDTH){1'b0}}, remain_reg};
        default: read_data = 32'h0;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    mem_valid  = 1'b0;
    mem_addr   = 32'h0;
    mem_wdata  = 32'h0;
    mem_wstrb  = 4'h0;
    case (state_reg)
      IDLE: begin
        if (start_req && (len_reg != '0)) state_next = READ;
      end
      READ: begin
        mem_valid = 1'b1;
        mem_addr  = {src_cnt_reg, 2'b00};
        if (mem_ready) state_next = GAP_R;
      end
      GAP_R: begin
        state_next = abort_hit ? IDLE : WRITE;
      end
      WRITE: begin
        mem_valid = 1'b1;
        mem_addr  = {dst_cnt_reg, 2'b00};
        mem_wdata = buf_reg;
        mem_wstrb = 4'hf;
        if (mem_ready) state_next = GAP_W;
      end
      GAP_W: begin
        // remain_reg == 1 means the decrement in this cycle reaches zero.
        state_next = (abort_hit || (remain_reg == LEN_WIDTH'(1))) ? IDLE : READ;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      src_reg        <= '0;
      dst_reg        <= '0;
      len_reg        <= '0;
      remain_reg     <= '0;
      buf_reg        <= '0;
      src_cnt_reg    <= '0;
      dst_cnt_reg    <= '0;
      done_reg       <= 1'b0;
      aborted_reg    <= 1'b0;
      abort_pend_reg <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (wr_en && !busy) begin
        case (address)
          8'h10:   src_reg <= write_data[31:2];
          8'h11:   dst_reg <= write_data[31:2];
          8'h12:   len_reg <= write_data[LEN_WIDTH-1:0];
          default: ;
        endcase
      end

      if (busy && (state_next == IDLE)) abort_pend_reg <= 1'b0;
      else if (busy && abort_req)       abort_pend_reg <= 1'b1;

      case (state_reg)
        IDLE: begin
          if (start_req) begin
            aborted_reg <= 1'b0;
            if (len_reg != '0) begin
              done_reg    <= 1'b0;
              src_cnt_reg <= src_reg;
              dst_cnt_reg <= dst_reg;
              remain_reg  <= len_reg;
            end else begin
              done_reg <= 1'b1;
            end
          end
        end
        READ: begin
          if (mem_ready) buf_reg <= mem_rdata;
        end
        GAP_R: begin
          if (abort_hit) begin
            aborted_reg <= 1'b1;
            done_reg    <= 1'b0;
          end
        end
        GAP_W: begin
          remain_reg  <= remain_reg - LEN_WIDTH'(1);
          src_cnt_reg <= src_cnt_reg + 30'd1;
          dst_cnt_reg <= dst_cnt_reg + 30'd1;
          if (abort_hit) begin
            aborted_reg <= 1'b1;
            done_reg    <= 1'b0;
          end else if (remain_reg == LEN_WIDTH'(1)) begin
            done_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
